// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: round-robin arbitration between ALU and memory writeback,
// a registered write port, and a busy scoreboard for hazard checks at issue.
module regfile_wb_scheduler #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              resv_valid,
    input  logic [ADDR_W-1:0] resv_rd,
    output logic              resv_ready,
    input  logic [ADDR_W-1:0] query_a,
    input  logic [ADDR_W-1:0] query_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              reg_wr,
    output logic [ADDR_W-1:0] rw,
    output logic [DATA_W-1:0] bus_w,
    output logic              wb_orphan
);

    localparam int unsigned       NumRegs = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(ZERO_REG);

    logic [NumRegs-1:0] busy_q, busy_d;
    logic               rr_q, rr_d;  // 0: req0 wins a tie, 1: req1 wins a tie
    logic               reg_wr_q, reg_wr_d;
    logic [ADDR_W-1:0]  rw_q, rw_d;
    logic [DATA_W-1:0]  bus_w_q, bus_w_d;
    logic               orphan_q, orphan_d;

    logic               grant0, grant1;
    logic [ADDR_W-1:0]  win_rd;
    logic [DATA_W-1:0]  win_data;
    logic               win_live;
    logic               resv_take;

    always_comb begin
        grant0   = rst_n & req0_valid & (~req1_valid | ~rr_q);
        grant1   = rst_n & req1_valid & (~req0_valid | rr_q);
        win_rd   = grant1 ? req1_rd : req0_rd;
        win_data = grant1 ? req1_data : req0_data;
        // ZERO_REG writebacks are acknowledged but never reach the write port
        win_live = (grant0 | grant1) & (win_rd != ZeroIdx);
    end

    always_comb begin
        resv_ready = (resv_rd == ZeroIdx) | ~busy_q[resv_rd];
        resv_take  = resv_valid & resv_ready & (resv_rd != ZeroIdx);
        busy_a     = (query_a != ZeroIdx) & busy_q[query_a];
        busy_b     = (query_b != ZeroIdx) & busy_q[query_b];
        req0_ready = grant0;
        req1_ready = grant1;
        reg_wr     = reg_wr_q;
        rw         = rw_q;
        bus_w      = bus_w_q;
        wb_orphan  = orphan_q;
    end

    always_comb begin
        busy_d = busy_q;
        // Clear only after the negedge commit of the staged write has happened
        if (reg_wr_q) begin
            busy_d[rw_q] = 1'b0;
        end
        if (resv_take) begin
            busy_d[resv_rd] = 1'b1;
        end

        rr_d = rr_q;
        if (grant0) begin
            rr_d = 1'b1;
        end else if (grant1) begin
            rr_d = 1'b0;
        end

        reg_wr_d = win_live;
        rw_d     = win_live ? win_rd : rw_q;
        bus_w_d  = win_live ? win_data : bus_w_q;
        orphan_d = orphan_q | (win_live & ~busy_q[win_rd]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            rr_q     <= 1'b0;
            reg_wr_q <= 1'b0;
            rw_q     <= '0;
            bus_w_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            rr_q     <= rr_d;
            reg_wr_q <= reg_wr_d;
            rw_q     <= rw_d;
            bus_w_q  <= bus_w_d;
            orphan_q <= orphan_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus random traffic, checked by a
// queue-based scoreboard fed from a cycle-level reference model of the scheduling rules.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        resv_valid = 1'b0;
    logic [4:0]  resv_rd = '0;
    logic        resv_ready;
    logic [4:0]  query_a = '0, query_b = '0;
    logic        busy_a, busy_b;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [4:0]  req0_rd = '0, req1_rd = '0;
    logic [63:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready;
    logic        reg_wr;
    logic [4:0]  rw;
    logic [63:0] bus_w;
    logic        wb_orphan;

    regfile_wb_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .resv_valid(resv_valid), .resv_rd(resv_rd), .resv_ready(resv_ready),
        .query_a(query_a), .query_b(query_b), .busy_a(busy_a), .busy_b(busy_b),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data),
        .req1_ready(req1_ready),
        .reg_wr(reg_wr), .rw(rw), .bus_w(bus_w), .wb_orphan(wb_orphan)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit r0; bit r1; bit rr; bit ba; bit bb; bit wr; bit orph;
    } exp_t;
    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } wr_t;

    exp_t comb_q[$];
    wr_t  wr_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: which registers await a write, who wins the next tie,
    // the sticky orphan flag, and the write visible on the port next cycle.
    bit mbusy[32];
    bit mfav;
    bit morph;
    bit mshow;
    int mshow_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
        mfav = 1'b0; morph = 1'b0; mshow = 1'b0; mshow_rd = 0;
    endtask

    task automatic step(input bit rv, input int rrd, input int qa, input int qb,
                        input bit v0, input int rd0, input logic [63:0] d0,
                        input bit v1, input int rd1, input logic [63:0] d1);
        exp_t e;
        wr_t w;
        bit g0, g1;
        int wrd;
        logic [63:0] wd;
        @(posedge clk);
        #1;
        resv_valid = rv; resv_rd = 5'(rrd); query_a = 5'(qa); query_b = 5'(qb);
        req0_valid = v0; req0_rd = 5'(rd0); req0_data = d0;
        req1_valid = v1; req1_rd = 5'(rd1); req1_data = d1;
        g0 = v0 && (!v1 || !mfav);
        g1 = v1 && (!v0 || mfav);
        e.r0 = g0; e.r1 = g1;
        e.rr = (rrd == 31) || !mbusy[rrd];
        e.ba = mbusy[qa]; e.bb = mbusy[qb];
        e.wr = mshow; e.orph = morph;
        comb_q.push_back(e);
        wrd = g1 ? rd1 : rd0;
        wd  = g1 ? d1 : d0;
        if ((g0 || g1) && wrd != 31) begin
            if (!mbusy[wrd]) morph = 1'b1;
            w.rd = 5'(wrd); w.data = wd;
            wr_q.push_back(w);
        end
        if (mshow) mbusy[mshow_rd] = 1'b0;
        if (rv && e.rr && rrd != 31) mbusy[rrd] = 1'b1;
        mshow = (g0 || g1) && wrd != 31;
        mshow_rd = wrd;
        if (g0) mfav = 1'b1;
        else if (g1) mfav = 1'b0;
    endtask

    function automatic int pick_rd();
        int bl[$];
        for (int i = 0; i < 32; i++) if (mbusy[i]) bl.push_back(i);
        if (bl.size() > 0 && $urandom_range(3) != 0) return bl[$urandom_range(bl.size() - 1)];
        return int'($urandom_range(31));
    endfunction

    task automatic rand_step();
        bit rv;
        int rrd;
        rv = 1'($urandom_range(1));
        rrd = int'($urandom_range(31));
        // Skip reserving a register whose orphan write is being committed this very cycle
        if (mshow && rrd == mshow_rd) rv = 1'b0;
        step(rv, rrd, pick_rd(), int'($urandom_range(31)),
             1'($urandom_range(1)), pick_rd(), {$urandom(), $urandom()},
             1'($urandom_range(1)), pick_rd(), {$urandom(), $urandom()});
    endtask

    task automatic idle(input int qa, input int qb);
        step(0, 0, qa, qb, 0, 0, 64'h0, 0, 0, 64'h0);
    endtask

    // Monitor: compares every cycle's outputs against the queued expectations
    always @(negedge clk) begin
        exp_t e;
        wr_t w;
        if (!rst_n) begin
            chk("reset_no_write", reg_wr, 0);
        end else if (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            chk("req0_ready", req0_ready, e.r0);
            chk("req1_ready", req1_ready, e.r1);
            chk("resv_ready", resv_ready, e.rr);
            chk("busy_a", busy_a, e.ba);
            chk("busy_b", busy_b, e.bb);
            chk("wb_orphan", wb_orphan, e.orph);
            chk("reg_wr", reg_wr, e.wr);
            if (e.wr) begin
                if (wr_q.size() == 0) begin
                    chk("wr_queue_nonempty", 0, 1);
                end else begin
                    w = wr_q.pop_front();
                    if (reg_wr) begin
                        chk("rw", rw, w.rd);
                        chk("bus_w", bus_w, w.data);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        #1;
        chk("rst_reg_wr", reg_wr, 0);
        chk("rst_rw", rw, 0);
        chk("rst_bus_w", bus_w, 0);
        chk("rst_orphan", wb_orphan, 0);
        #11 rst_n = 1'b1;

        // Reserve x5, write it back, watch busy drop two edges after the grant
        step(1, 5, 5, 0, 0, 0, 64'h0, 0, 0, 64'h0);
        step(0, 0, 5, 0, 1, 5, 64'hDEAD, 0, 0, 64'h0);
        idle(5, 0);
        idle(5, 0);
        idle(5, 0);
        // Zero-register writeback: acknowledged, dropped, no orphan; pointer back to req0
        step(0, 0, 31, 0, 0, 0, 64'h0, 1, 31, 64'h1);
        idle(0, 0);
        // Tie stream: alternating grants, orphan on the third
        step(1, 3, 3, 4, 0, 0, 64'h0, 0, 0, 64'h0);
        step(1, 4, 3, 4, 0, 0, 64'h0, 0, 0, 64'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 3, 4, 1, 3, 64'h300 + 64'(i), 1, 4, 64'h400 + 64'(i));
        idle(3, 4);
        idle(3, 4);
        // Reservation blocked while busy; zero register is always accepted and never busy
        step(1, 7, 7, 31, 0, 0, 64'h0, 0, 0, 64'h0);
        step(1, 7, 7, 31, 0, 0, 64'h0, 0, 0, 64'h0);
        step(1, 31, 31, 7, 0, 0, 64'h0, 0, 0, 64'h0);
        idle(31, 7);
        // Set of x9 and clear of x2 in the same cycle
        step(1, 2, 2, 9, 0, 0, 64'h0, 0, 0, 64'h0);
        step(0, 0, 2, 9, 1, 2, 64'h22, 0, 0, 64'h0);
        step(1, 9, 2, 9, 0, 0, 64'h0, 0, 0, 64'h0);
        idle(9, 2);
        idle(9, 2);

        for (int i = 0; i < 2000; i++) rand_step();

        // Reset asserted while a write is staged on the port
        step(1, 12, 12, 0, 0, 0, 64'h0, 0, 0, 64'h0);
        step(0, 0, 12, 12, 1, 12, 64'hC0FFEE, 0, 0, 64'h0);
        idle(12, 12);
        #1;
        chk("staged_before_reset", reg_wr, mshow ? 0 : 1);
        rst_n = 1'b0;
        comb_q.delete();
        wr_q.delete();
        model_reset();
        #1;
        chk("async_reg_wr", reg_wr, 0);
        chk("async_rw", rw, 0);
        chk("async_bus_w", bus_w, 0);
        chk("async_busy", busy_a, 0);
        chk("async_orphan", wb_orphan, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("reset_req0_ready", req0_ready, 0);
        chk("reset_req1_ready", req1_ready, 0);
        repeat (2) @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; resv_valid = 1'b0;
        #2 rst_n = 1'b1;

        for (int i = 0; i < 300; i++) rand_step();
        idle(0, 0);
        idle(0, 0);
        idle(0, 0);
        @(negedge clk);
        #1;
        chk("comb_q_drained", 64'(comb_q.size()), 0);
        chk("wr_q_drained", 64'(wr_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
